// File: rtl/usb_rx_nrzi_unstuff.sv
// Full-speed USB receive bit layer: SYNC hunt, NRZI decode, bit unstuffing, LSB-first bytes, EOP/error flags.
// All outputs registered one cycle after the deciding strobe; no backpressure, every rx_valid must be taken.
module usb_rx_nrzi_unstuff #(
    parameter int SYNC_MIN_TRANS = 3,
    parameter int EOP_SE0_MAX    = 3,
    parameter int IDLE_J_BITS    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic       dp,
    input  logic       dm,
    output logic       rx_active,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_eop,
    output logic       rx_eop_err,
    output logic       rx_stuff_err
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_EOP  = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    localparam int ZW = $clog2(SYNC_MIN_TRANS + 1);
    localparam int SW = $clog2(EOP_SE0_MAX + 2);
    localparam int JW = $clog2(IDLE_J_BITS + 1);

    logic [2:0]    state;
    logic          prev_k;
    logic [ZW-1:0] zero_cnt;
    logic [2:0]    ones_cnt;
    logic [2:0]    bit_cnt;
    logic [SW-1:0] se0_cnt;
    logic [JW-1:0] j_cnt;
    logic          align_err;
    logic [6:0]    shift;

    logic is_j;
    logic is_k;
    logic is_se0;
    logic d;

    // SE1 (11) is not a valid differential state and falls into the SE0 bucket
    assign is_j   = dp & ~dm;
    assign is_k   = ~dp & dm;
    assign is_se0 = ~(is_j | is_k);
    assign d      = (is_k == prev_k);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            prev_k       <= 1'b0;
            zero_cnt     <= '0;
            ones_cnt     <= '0;
            bit_cnt      <= '0;
            se0_cnt      <= '0;
            j_cnt        <= '0;
            align_err    <= 1'b0;
            shift        <= '0;
            rx_active    <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= 8'h00;
            rx_eop       <= 1'b0;
            rx_eop_err   <= 1'b0;
            rx_stuff_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_eop       <= 1'b0;
            rx_eop_err   <= 1'b0;
            rx_stuff_err <= 1'b0;
            if (sample_en) begin
                if (!is_se0) begin
                    prev_k <= is_k;
                end
                case (state)
                    ST_IDLE: begin
                        if (is_k) begin
                            state    <= ST_SYNC;
                            zero_cnt <= ZW'(1);
                        end
                    end
                    ST_SYNC: begin
                        if (is_se0) begin
                            state <= ST_IDLE;
                        end else if (!d) begin
                            if (zero_cnt != ZW'(SYNC_MIN_TRANS)) begin
                                zero_cnt <= zero_cnt + 1'b1;
                            end
                        end else if (zero_cnt >= ZW'(SYNC_MIN_TRANS)) begin
                            // The closing KK of SYNC is itself a decoded 1 for stuffing purposes
                            state     <= ST_DATA;
                            rx_active <= 1'b1;
                            ones_cnt  <= 3'd1;
                            bit_cnt   <= 3'd0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        if (is_se0) begin
                            state     <= ST_EOP;
                            se0_cnt   <= SW'(1);
                            align_err <= (bit_cnt != 3'd0);
                        end else if (ones_cnt == 3'd6) begin
                            if (d) begin
                                rx_stuff_err <= 1'b1;
                                rx_active    <= 1'b0;
                                j_cnt        <= '0;
                                state        <= ST_ERR;
                            end else begin
                                ones_cnt <= 3'd0;
                            end
                        end else begin
                            ones_cnt <= d ? ones_cnt + 3'd1 : 3'd0;
                            if (bit_cnt == 3'd7) begin
                                rx_valid <= 1'b1;
                                rx_data  <= {d, shift};
                                bit_cnt  <= 3'd0;
                            end else begin
                                shift[bit_cnt] <= d;
                                bit_cnt        <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    ST_EOP: begin
                        if (is_se0) begin
                            if (se0_cnt != SW'(EOP_SE0_MAX + 1)) begin
                                se0_cnt <= se0_cnt + 1'b1;
                            end
                        end else begin
                            rx_eop    <= 1'b1;
                            rx_active <= 1'b0;
                            if (is_j) begin
                                rx_eop_err <= align_err | (se0_cnt > SW'(EOP_SE0_MAX));
                                state      <= ST_IDLE;
                            end else begin
                                rx_eop_err <= 1'b1;
                                j_cnt      <= '0;
                                state      <= ST_ERR;
                            end
                        end
                    end
                    ST_ERR: begin
                        if (is_j) begin
                            if (j_cnt == JW'(IDLE_J_BITS - 1)) begin
                                j_cnt <= '0;
                                state <= ST_IDLE;
                            end else begin
                                j_cnt <= j_cnt + 1'b1;
                            end
                        end else begin
                            j_cnt <= '0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_nrzi_unstuff.sv
// Bench: encodes packets (SYNC, NRZI, stuffing, EOP) from byte lists and checks the decoded stream.
module tb_usb_rx_nrzi_unstuff;

    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;
    localparam logic [1:0] LSE1 = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_en = 1'b0;
    logic       dp = 1'b1;
    logic       dm = 1'b0;
    logic       rx_active, rx_valid, rx_eop, rx_eop_err, rx_stuff_err;
    logic [7:0] rx_data;

    usb_rx_nrzi_unstuff dut (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .dp           (dp),
        .dm           (dm),
        .rx_active    (rx_active),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_eop       (rx_eop),
        .rx_eop_err   (rx_eop_err),
        .rx_stuff_err (rx_stuff_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         nbits;
        int         se0;
        bit         nostuff;
        bit         gaps;
        int         exp_n;
        logic [7:0] e0;
        logic [7:0] e1;
        int         exp_eop;
        bit         exp_err;
        int         exp_stuff;
    } vec_t;

    vec_t       vt[12];
    int         n_chk = 0;
    int         n_fail = 0;
    bit         pkt_bits[$];
    logic [7:0] exp_bytes[$];
    logic [1:0] line_q[$];

    // Monitor: only this block writes the observation state
    logic [7:0] got_bytes[$];
    int         eop_cnt = 0, stuff_cnt = 0, rise_cnt = 0, viol_cnt = 0;
    logic       last_eop_err = 1'b0, active_d = 1'b0;
    int         b_bytes, b_eop, b_stuff, b_rise, b_viol;

    always @(negedge clk) begin
        if (rst) begin
            active_d = 1'b0;
        end else begin
            if (rx_valid) got_bytes.push_back(rx_data);
            if (rx_eop) begin
                eop_cnt++;
                last_eop_err = rx_eop_err;
            end
            if (rx_stuff_err) stuff_cnt++;
            if (rx_valid && !rx_active) viol_cnt++;
            if (rx_eop_err && !rx_eop) viol_cnt++;
            if (rx_eop && (rx_valid || rx_stuff_err || rx_active)) viol_cnt++;
            if (rx_active && !active_d) rise_cnt++;
            active_d = rx_active;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic snap();
        b_bytes = got_bytes.size();
        b_eop   = eop_cnt;
        b_stuff = stuff_cnt;
        b_rise  = rise_cnt;
        b_viol  = viol_cnt;
    endtask

    task automatic load_bits(input logic [7:0] b0, input logic [7:0] b1, input int nbits);
        pkt_bits.delete();
        for (int i = 0; i < nbits; i++) pkt_bits.push_back(i < 8 ? b0[i] : b1[i-8]);
    endtask

    // Transmitter model: idle, SYNC, NRZI with a 0 inserted after every six 1s, SE0 run, J
    task automatic build_line(input bit nostuff, input int se0);
        logic [1:0] cur;
        int         ones;
        line_q.delete();
        repeat (4) line_q.push_back(LJ);
        for (int i = 0; i < 7; i++) line_q.push_back((i % 2 == 0) ? LK : LJ);
        line_q.push_back(LK);
        cur  = LK;
        ones = 1;
        foreach (pkt_bits[i]) begin
            if (!pkt_bits[i]) cur = (cur == LJ) ? LK : LJ;
            line_q.push_back(cur);
            ones = pkt_bits[i] ? ones + 1 : 0;
            if (ones == 6 && !nostuff) begin
                cur = (cur == LJ) ? LK : LJ;
                line_q.push_back(cur);
                ones = 0;
            end
        end
        repeat (se0) line_q.push_back($urandom_range(0, 1) ? LSE1 : LSE0);
        repeat (11) line_q.push_back(LJ);
    endtask

    task automatic drive_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            {dp, dm}  = line_q[i];
            sample_en = 1'b1;
            @(negedge clk);
            sample_en = 1'b0;
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_pkt(input string nm, input int exp_eop, input bit exp_err,
                             input int exp_stuff, input int exp_rise);
        int nb;
        nb = got_bytes.size() - b_bytes;
        chk({nm, "_nbytes"}, nb, exp_bytes.size());
        for (int i = 0; i < nb && i < exp_bytes.size(); i++)
            chk({nm, "_data"}, int'(got_bytes[b_bytes+i]), int'(exp_bytes[i]));
        chk({nm, "_eop"}, eop_cnt - b_eop, exp_eop);
        if (exp_eop == 1 && eop_cnt - b_eop == 1)
            chk({nm, "_eop_err"}, int'(last_eop_err), int'(exp_err));
        chk({nm, "_stuff_err"}, stuff_cnt - b_stuff, exp_stuff);
        chk({nm, "_active_rise"}, rise_cnt - b_rise, exp_rise);
        chk({nm, "_pulse_rules"}, viol_cnt - b_viol, 0);
        chk({nm, "_active_end"}, int'(rx_active), 0);
    endtask

    task automatic run_pkt(input string nm, input bit nostuff, input int se0, input bit gaps,
                           input int exp_eop, input bit exp_err, input int exp_stuff);
        build_line(nostuff, se0);
        snap();
        drive_range(0, line_q.size() - 1, gaps);
        drain();
        check_pkt(nm, exp_eop, exp_err, exp_stuff, 1);
    endtask

    task automatic run_silent(input string nm);
        repeat (6) line_q.push_back(LJ);
        snap();
        drive_range(0, line_q.size() - 1, 1'b0);
        drain();
        exp_bytes.delete();
        check_pkt(nm, 0, 1'b0, 0, 0);
    endtask

    int         nb, extra, se0;
    logic [7:0] rb;

    initial begin
        vt[0]  = '{8'hA5, 8'h00,  8, 2, 1'b0, 1'b0, 1, 8'hA5, 8'h00, 1, 1'b0, 0};
        vt[1]  = '{8'hFF, 8'h01, 16, 2, 1'b0, 1'b0, 2, 8'hFF, 8'h01, 1, 1'b0, 0};
        vt[2]  = '{8'hFF, 8'h01, 16, 2, 1'b1, 1'b0, 0, 8'h00, 8'h00, 0, 1'b0, 1};
        vt[3]  = '{8'h96, 8'h0B, 12, 2, 1'b0, 1'b0, 1, 8'h96, 8'h00, 1, 1'b1, 0};
        vt[4]  = '{8'h3C, 8'h00,  8, 5, 1'b0, 1'b0, 1, 8'h3C, 8'h00, 1, 1'b1, 0};
        vt[5]  = '{8'h5A, 8'h00,  8, 2, 1'b0, 1'b0, 1, 8'h5A, 8'h00, 1, 1'b0, 0};
        vt[6]  = '{8'h5A, 8'h00,  8, 2, 1'b0, 1'b1, 1, 8'h5A, 8'h00, 1, 1'b0, 0};
        vt[7]  = '{8'h00, 8'h00,  8, 3, 1'b0, 1'b0, 1, 8'h00, 8'h00, 1, 1'b0, 0};
        vt[8]  = '{8'h7E, 8'h00,  8, 4, 1'b0, 1'b1, 1, 8'h7E, 8'h00, 1, 1'b1, 0};
        vt[9]  = '{8'hFC, 8'h00,  8, 2, 1'b0, 1'b0, 1, 8'hFC, 8'h00, 1, 1'b0, 0};
        vt[10] = '{8'hFC, 8'h00,  8, 2, 1'b1, 1'b0, 1, 8'hFC, 8'h00, 1, 1'b0, 0};
        vt[11] = '{8'h81, 8'h00,  8, 1, 1'b0, 1'b1, 1, 8'h81, 8'h00, 1, 1'b0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_active", int'(rx_active), 0);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_eop", int'(rx_eop), 0);
        chk("rst_eop_err", int'(rx_eop_err), 0);
        chk("rst_stuff_err", int'(rx_stuff_err), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed table
        foreach (vt[i]) begin
            load_bits(vt[i].b0, vt[i].b1, vt[i].nbits);
            exp_bytes.delete();
            if (vt[i].exp_n > 0) exp_bytes.push_back(vt[i].e0);
            if (vt[i].exp_n > 1) exp_bytes.push_back(vt[i].e1);
            run_pkt($sformatf("vec%0d", i), vt[i].nostuff, vt[i].se0, vt[i].gaps,
                    vt[i].exp_eop, vt[i].exp_err, vt[i].exp_stuff);
        end

        // Byte appears exactly one cycle after the strobe carrying its 8th bit
        load_bits(8'hA5, 8'h00, 8);
        exp_bytes = '{8'hA5};
        build_line(1'b0, 2);
        snap();
        drive_range(0, 18, 1'b0);
        chk("lat_before", int'(rx_valid), 0);
        drive_range(19, 19, 1'b0);
        chk("lat_valid", int'(rx_valid), 1);
        chk("lat_data", int'(rx_data), 8'hA5);
        chk("lat_active", int'(rx_active), 1);
        drive_range(20, line_q.size() - 1, 1'b0);
        drain();
        check_pkt("lat_pkt", 1, 1'b0, 0, 1);

        // Aborted SYNC attempts produce nothing, then a full packet still decodes
        line_q = '{LJ, LJ, LK, LJ, LJ};
        run_silent("glitch_kjj");
        line_q = '{LJ, LK, LK};
        run_silent("sync_kk");
        line_q = '{LJ, LK, LJ, LSE0};
        run_silent("sync_se0");
        load_bits(8'h5A, 8'h00, 8);
        exp_bytes = '{8'h5A};
        run_pkt("after_glitch", 1'b0, 2, 1'b1, 1, 1'b0, 0);

        // Reset in the middle of a byte
        load_bits(8'hC3, 8'h00, 8);
        build_line(1'b0, 2);
        drive_range(0, 15, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_active", int'(rx_active), 0);
        chk("mid_rst_valid", int'(rx_valid), 0);
        chk("mid_rst_data", int'(rx_data), 0);
        chk("mid_rst_eop", int'(rx_eop), 0);
        chk("mid_rst_eop_err", int'(rx_eop_err), 0);
        chk("mid_rst_stuff", int'(rx_stuff_err), 0);
        rst = 1'b0;
        line_q.delete();
        run_silent("post_rst_idle");
        load_bits(8'hC3, 8'h00, 8);
        exp_bytes = '{8'hC3};
        run_pkt("post_rst_pkt", 1'b0, 2, 1'b0, 1, 1'b0, 0);

        // Random packets against the transmitter model
        for (int p = 0; p < 24; p++) begin
            nb    = $urandom_range(1, 3);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            se0   = $urandom_range(1, 5);
            pkt_bits.delete();
            exp_bytes.delete();
            for (int k = 0; k < nb; k++) begin
                rb = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
                exp_bytes.push_back(rb);
                for (int j = 0; j < 8; j++) pkt_bits.push_back(rb[j]);
            end
            repeat (extra) pkt_bits.push_back(1'($urandom));
            run_pkt($sformatf("rand%0d", p), 1'b0, se0, 1'($urandom), 1,
                    (extra != 0) || (se0 > 3), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
